ram_lsu: RTL and testbench

Load/store initiator that drives one word-wide, word-addressed dual-port RAM. The RAM has one write port and one read port, returns read data one cycle after `ren`, and has no byte enables. The block accepts byte-addressed load/store requests from the core pipeline over a valid/ready handshake. It performs byte/half/word loads with sign or zero extension and implements sub-word stores as read-modify-write. It sits between the core's memory stage and the data RAM instance.

---
 rtl/ram_lsu.sv | 181 ++++++++++++++++++
 tb/tb_ram_lsu.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_lsu.sv
// ram_lsu: byte-addressed load/store front end for a word-wide dual-port RAM.
// Sub-word stores are done as read-modify-write; loads are sign/zero extended.
module ram_lsu #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          ram_wen,
  output logic [AW-1:0] ram_waddr,
  output logic [31:0]   ram_wdata,
  output logic          ram_ren,
  output logic [AW-1:0] ram_raddr,
  input  logic [31:0]   ram_rdata
);

  typedef enum logic [2:0] {
    IDLE, RD, DATA, WR, ERR
  } state_t;

  state_t state, state_nx;

  logic          we_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;

  logic          accept;
  logic          hi_bad;
  logic          bad;
  logic [AW-1:0] word_q;
  logic [1:0]    lane;
  logic [7:0]    ld_b;
  logic [15:0]   ld_h;
  logic [31:0]   ld_data;
  logic [31:0]   st_mask;
  logic [31:0]   st_ins;
  logic [31:0]   st_word;

  assign accept = req_valid && req_ready;
  assign hi_bad = (req_addr >> (AW + 2)) != 32'd0;
  assign bad = (req_size == 2'b11)
             | ((req_size == 2'b01) & req_addr[0])
             | ((req_size == 2'b10) & (|req_addr[1:0]))
             | hi_bad;

  assign word_q = addr_q[AW+1:2];
  assign lane   = addr_q[1:0];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        we_q    <= req_we;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        addr_q  <= req_addr[AW+1:0];
        wdata_q <= req_wdata;
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          if (bad)
            state_nx = ERR;
          else if (req_we && req_size == 2'b10)
            state_nx = WR;
          else
            state_nx = RD;
        end
      end
      RD:      state_nx = DATA;
      DATA:    state_nx = IDLE;
      WR:      state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Lane extraction and extension for loads
  assign ld_b = ram_rdata[{lane, 3'b000} +: 8];
  assign ld_h = ram_rdata[{lane[1], 4'b0000} +: 16];

  always_comb begin
    ld_data = ram_rdata;
    unique case (1'b1)
      size_q == 2'b00:
        ld_data = {{24{~uns_q & ld_b[7]}}, ld_b};
      size_q == 2'b01:
        ld_data = {{16{~uns_q & ld_h[15]}}, ld_h};
      default:
        ld_data = ram_rdata;
    endcase
  end

  // Merge the store bytes into the word just read
  always_comb begin
    st_mask = 32'h0000_0000;
    st_ins  = 32'h0000_0000;
    unique case (1'b1)
      size_q == 2'b00: begin
        st_mask = 32'h0000_00ff << {lane, 3'b000};
        st_ins  = {24'd0, wdata_q[7:0]} << {lane, 3'b000};
      end
      size_q == 2'b01: begin
        st_mask = 32'h0000_ffff << {lane[1], 4'b0000};
        st_ins  = {16'd0, wdata_q[15:0]} << {lane[1], 4'b0000};
      end
      default: begin
        st_mask = 32'hffff_ffff;
        st_ins  = wdata_q;
      end
    endcase
  end

  assign st_word = (ram_rdata & ~st_mask) | st_ins;

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    ram_wen   = 1'b0;
    ram_waddr = '0;
    ram_wdata = '0;
    ram_ren   = 1'b0;
    ram_raddr = '0;
    if (rstn) begin
      unique case (state)
        IDLE: req_ready = 1'b1;
        RD: begin
          ram_ren   = 1'b1;
          ram_raddr = word_q;
        end
        DATA: begin
          rsp_valid = 1'b1;
          if (we_q) begin
            ram_wen   = 1'b1;
            ram_waddr = word_q;
            ram_wdata = st_word;
          end else begin
            rsp_rdata = ld_data;
          end
        end
        WR: begin
          rsp_valid = 1'b1;
          ram_wen   = 1'b1;
          ram_waddr = word_q;
          ram_wdata = wdata_q;
        end
        ERR: begin
          rsp_valid = 1'b1;
          rsp_err   = 1'b1;
        end
        default: req_ready = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_lsu.sv
// tb_ram_lsu: table vectors, hand sequences and random ops against a
// byte-level memory model; the bench also plays the part of the RAM.
module tb_ram_lsu;

  localparam int AW    = 12;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic          req_unsigned = 1'b0;
  logic [31:0]   req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          ram_wen;
  logic [AW-1:0] ram_waddr;
  logic [31:0]   ram_wdata;
  logic          ram_ren;
  logic [AW-1:0] ram_raddr;
  logic [31:0]   ram_rdata;

  always #5 clk = ~clk;

  ram_lsu #(.AW(AW)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .ram_wen      (ram_wen),
    .ram_waddr    (ram_waddr),
    .ram_wdata    (ram_wdata),
    .ram_ren      (ram_ren),
    .ram_raddr    (ram_raddr),
    .ram_rdata    (ram_rdata)
  );

  logic [31:0] ram [DEPTH];
  bit          ram_clr_done;

  always @(posedge clk) begin
    if (!ram_clr_done) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
      ram_clr_done <= 1'b1;
    end else if (ram_wen) begin
      ram[ram_waddr] <= ram_wdata;
    end
    if (ram_ren) ram_rdata <= ram[ram_raddr];
  end

  int vectors = 0;
  int fails   = 0;
  bit mon_en  = 1'b0;

  logic [31:0] ref_mem [DEPTH];

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: bytes of a word, byte-addressed lanes, plain arithmetic
  function automatic void model(input logic we, input logic [1:0] size,
                                input logic uns, input logic [31:0] addr,
                                input logic [31:0] wdata,
                                output logic err, output logic [31:0] rd,
                                output int lat);
    logic [7:0]  b [4];
    logic [31:0] word;
    logic [15:0] h;
    int          widx, ln;
    err = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0)
       || (size == 2'd2 && addr % 4 != 0) || (addr >= 4 * DEPTH);
    rd  = '0;
    lat = 1;
    if (err) return;
    widx = int'(addr / 4);
    ln   = int'(addr % 4);
    word = ref_mem[widx];
    for (int i = 0; i < 4; i++) b[i] = word[8*i +: 8];
    if (we) begin
      if (size == 2'd2) begin
        ref_mem[widx] = wdata;
        return;
      end
      lat   = 2;
      b[ln] = wdata[7:0];
      if (size == 2'd1) b[ln+1] = wdata[15:8];
      ref_mem[widx] = {b[3], b[2], b[1], b[0]};
      return;
    end
    lat = 2;
    if (size == 2'd0)
      rd = uns ? {24'd0, b[ln]} : {{24{b[ln][7]}}, b[ln]};
    else if (size == 2'd1) begin
      h  = {b[ln+1], b[ln]};
      rd = uns ? {16'd0, h} : {{16{h[15]}}, h};
    end else
      rd = word;
  endfunction

  function automatic vec_t mk(input logic we, input logic [1:0] size,
                              input logic uns, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic err,
                              input logic [31:0] rdata, input int lat);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr;
    v.wdata = wdata; v.err = err; v.rdata = rdata; v.lat = lat;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    req_valid    = 1'b1;
    req_we       = v.we;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
  endtask

  // Called at a negedge in an IDLE cycle; returns at the next IDLE negedge
  task automatic do_req(input vec_t v, input string tag);
    logic        got, seen_ren, seen_strb, wen_at, err_at;
    logic [31:0] ren_addr, waddr_at, rd_at;
    logic        exp_wen, exp_ren;
    int          k, widx;
    chk({tag, " ready"}, {31'd0, req_ready}, 32'd1);
    drive(v);
    @(posedge clk);
    #1 req_valid = 1'b0;
    got = 0; seen_ren = 0; seen_strb = 0; k = 0;
    ren_addr = '0; waddr_at = '0; rd_at = '0; wen_at = 0; err_at = 0;
    for (int c = 1; c <= 6 && !got; c++) begin
      @(negedge clk);
      if (ram_ren) begin
        seen_ren = 1;
        ren_addr = {20'd0, ram_raddr};
      end
      if (ram_ren || ram_wen) seen_strb = 1;
      if (rsp_valid) begin
        got = 1; k = c;
        wen_at = ram_wen; waddr_at = {20'd0, ram_waddr};
        err_at = rsp_err; rd_at = rsp_rdata;
      end
    end
    if (!got) begin
      vectors++; fails++;
      $display("FAIL %s timeout: no rsp_valid within 6 cycles", tag);
      @(negedge clk);
      return;
    end
    exp_wen = v.we && !v.err;
    exp_ren = !v.err && !(v.we && v.size == 2'd2);
    chk({tag, " latency"}, k, v.lat);
    chk({tag, " err"}, {31'd0, err_at}, {31'd0, v.err});
    chk({tag, " rdata"}, rd_at, v.rdata);
    chk({tag, " wen"}, {31'd0, wen_at}, {31'd0, exp_wen});
    chk({tag, " ren"}, {31'd0, seen_ren}, {31'd0, exp_ren});
    if (exp_wen)
      chk({tag, " waddr"}, waddr_at, {20'd0, v.addr[13:2]});
    if (exp_ren)
      chk({tag, " raddr"}, ren_addr, {20'd0, v.addr[13:2]});
    if (v.err)
      chk({tag, " strobe"}, {31'd0, seen_strb}, 32'd0);
    @(negedge clk);
    if (exp_wen) begin
      widx = int'(v.addr[13:2]);
      chk({tag, " mem"}, ram[widx], ref_mem[widx]);
    end
  endtask

  task automatic run_model(input vec_t v);
    logic        e;
    logic [31:0] r;
    int          l;
    model(v.we, v.size, v.uns, v.addr, v.wdata, e, r, l);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      vectors++;
      if ((ram_wen && ram_ren)
          || (!ram_wen && (ram_waddr != '0 || ram_wdata != '0))
          || (!ram_ren && ram_raddr != '0)
          || (!rsp_valid && (rsp_err || rsp_rdata != '0))) begin
        fails++;
        $display("FAIL invariant: wen=%b ren=%b wa=%h wd=%h ra=%h v=%b e=%b rd=%h",
                 ram_wen, ram_ren, ram_waddr, ram_wdata, ram_raddr,
                 rsp_valid, rsp_err, rsp_rdata);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [$];
    vec_t        bb [4];
    vec_t        v;
    logic        e;
    logic [31:0] r;
    int          l, idx, nrsp;
    logic        prev_rsp;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    repeat (3) @(negedge clk);
    chk("reset ready", {31'd0, req_ready}, 32'd0);
    chk("reset wen", {31'd0, ram_wen}, 32'd0);
    chk("reset ren", {31'd0, ram_ren}, 32'd0);
    chk("reset rsp", {31'd0, rsp_valid}, 32'd0);
    rstn = 1'b1;
    #1;
    chk("post-reset ready", {31'd0, req_ready}, 32'd1);
    chk("post-reset rdata", rsp_rdata, 32'd0);
    mon_en = 1'b1;
    @(negedge clk);

    tbl.push_back(mk(1, 2, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0, 1));
    tbl.push_back(mk(0, 2, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF, 2));
    tbl.push_back(mk(1, 2, 0, 32'h20, 32'h80FF7F01, 0, 32'h0, 1));
    tbl.push_back(mk(0, 0, 0, 32'h23, 32'h0, 0, 32'hFFFFFF80, 2));
    tbl.push_back(mk(0, 0, 1, 32'h23, 32'h0, 0, 32'h00000080, 2));
    tbl.push_back(mk(0, 1, 0, 32'h20, 32'h0, 0, 32'h00007F01, 2));
    tbl.push_back(mk(0, 1, 1, 32'h22, 32'h0, 0, 32'h000080FF, 2));
    tbl.push_back(mk(0, 1, 0, 32'h22, 32'h0, 0, 32'hFFFF80FF, 2));
    tbl.push_back(mk(1, 2, 0, 32'h30, 32'h11223344, 0, 32'h0, 1));
    tbl.push_back(mk(1, 0, 0, 32'h31, 32'h555555AB, 0, 32'h0, 2));
    tbl.push_back(mk(0, 2, 0, 32'h30, 32'h0, 0, 32'h1122AB44, 2));
    tbl.push_back(mk(1, 1, 0, 32'h32, 32'h7777CDEF, 0, 32'h0, 2));
    tbl.push_back(mk(0, 2, 0, 32'h30, 32'h0, 0, 32'hCDEFAB44, 2));
    tbl.push_back(mk(0, 2, 0, 32'h02, 32'h0, 1, 32'h0, 1));
    tbl.push_back(mk(0, 1, 0, 32'h05, 32'h0, 1, 32'h0, 1));
    tbl.push_back(mk(0, 3, 0, 32'h40, 32'h0, 1, 32'h0, 1));
    tbl.push_back(mk(0, 2, 0, 32'h4000, 32'h0, 1, 32'h0, 1));
    tbl.push_back(mk(1, 2, 0, 32'hFFFFFFFC, 32'h1, 1, 32'h0, 1));
    tbl.push_back(mk(1, 1, 0, 32'h33, 32'h1, 1, 32'h0, 1));
    tbl.push_back(mk(1, 2, 0, 32'h3FFC, 32'hA5B6C7D8, 0, 32'h0, 1));
    tbl.push_back(mk(0, 0, 0, 32'h3FFF, 32'h0, 0, 32'hFFFFFFA5, 2));
    tbl.push_back(mk(0, 1, 0, 32'h3FFE, 32'h0, 0, 32'hFFFFA5B6, 2));
    tbl.push_back(mk(0, 0, 1, 32'h3FFD, 32'h0, 0, 32'h000000C7, 2));

    foreach (tbl[i]) begin
      run_model(tbl[i]);
      do_req(tbl[i], $sformatf("tbl%0d", i));
    end

    // Back-to-back with req_valid held high
    bb[0] = mk(1, 2, 0, 32'h40, 32'h12345678, 0, 0, 0);
    bb[1] = mk(0, 2, 0, 32'h40, 32'h0, 0, 0, 0);
    bb[2] = mk(1, 0, 0, 32'h41, 32'h99, 0, 0, 0);
    bb[3] = mk(0, 2, 0, 32'h40, 32'h0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      model(bb[i].we, bb[i].size, bb[i].uns, bb[i].addr, bb[i].wdata,
            e, r, l);
      bb[i].err = e; bb[i].rdata = r; bb[i].lat = l;
    end
    chk("bb model last", bb[3].rdata, 32'h12349978);
    idx = 0; nrsp = 0; prev_rsp = 0;
    drive(bb[0]);
    for (int c = 0; c < 40 && nrsp < 4; c++) begin
      chk("bb ready&rsp", {31'd0, req_ready & rsp_valid}, 32'd0);
      if (prev_rsp) begin
        chk("bb rsp one cycle", {31'd0, rsp_valid}, 32'd0);
        if (idx < 4) chk("bb ready after rsp", {31'd0, req_ready}, 32'd1);
      end
      if (rsp_valid) begin
        chk("bb outstanding", idx - nrsp, 1);
        chk("bb err", {31'd0, rsp_err}, {31'd0, bb[nrsp].err});
        chk("bb rdata", rsp_rdata, bb[nrsp].rdata);
        nrsp++;
      end
      prev_rsp = rsp_valid;
      if (req_ready && idx < 4) begin
        idx++;
        @(posedge clk);
        #1;
        if (idx < 4) drive(bb[idx]);
        else req_valid = 1'b0;
      end else begin
        @(posedge clk);
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("bb accepts", idx, 4);
    chk("bb responses", nrsp, 4);
    chk("bb mem", ram[16], ref_mem[16]);

    // Reset during the write cycle of a sub-word store
    v = mk(1, 2, 0, 32'h50, 32'h0BADF00D, 0, 32'h0, 1);
    run_model(v);
    do_req(v, "rst pre");
    drive(mk(1, 0, 0, 32'h50, 32'h77, 0, 0, 0));
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rst rd ren", {31'd0, ram_ren}, 32'd1);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("rst data wen", {31'd0, ram_wen}, 32'd0);
    chk("rst data rsp", {31'd0, rsp_valid}, 32'd0);
    chk("rst data ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("rst hold wen", {31'd0, ram_wen}, 32'd0);
    chk("rst hold rsp", {31'd0, rsp_valid}, 32'd0);
    rstn = 1'b1;
    #1;
    chk("rst release ready", {31'd0, req_ready}, 32'd1);
    chk("rst mem kept", ram[20], 32'h0BADF00D);
    v = mk(0, 2, 0, 32'h50, 32'h0, 0, 32'h0BADF00D, 2);
    run_model(v);
    do_req(v, "rst post");

    // Random operations against the model
    for (int n = 0; n < 300; n++) begin
      v.we    = 1'($urandom_range(0, 1));
      v.size  = 2'($urandom_range(0, 3));
      v.uns   = 1'($urandom_range(0, 1));
      v.wdata = $urandom();
      if ($urandom_range(0, 7) == 0)
        v.addr = $urandom() | 32'h0000_4000;
      else
        v.addr = $urandom_range(0, 127);
      model(v.we, v.size, v.uns, v.addr, v.wdata, e, r, l);
      v.err = e; v.rdata = r; v.lat = l;
      do_req(v, $sformatf("rnd%0d", n));
    end

    for (int i = 0; i < 32; i++)
      chk($sformatf("final mem%0d", i), ram[i], ref_mem[i]);
    chk("final mem top", ram[DEPTH-1], ref_mem[DEPTH-1]);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
